basic_and_ff: RTL and testbench
===============================

// Module: basic_and_ff
// PURPOSE
//   Registered bitwise AND cell: samples a & b on the rising clock edge and
//   drives the result on out after a fixed pipeline latency.
//   Leaf cell for gate-level timing flows: its clk->out path and the a/b
//   setup/hold checks are the arcs the cell's SDF file annotates.
//   Reused as a timing-characterisation target and as a small synchronous
//   AND stage in datapaths.
// PARAMETERS
//   WIDTH   1   bit width of a, b, out; bitwise AND per lane.
//   STAGES  1   register stages between inputs and out; legal 1..8.
// PORTS
//   clk  input   1      rising-edge clock; the only clock.
//   rst  input   1      synchronous, active-high reset.
//   a    input   WIDTH  operand A.
//   b    input   WIDTH  operand B.
//   out  output  WIDTH  registered a & b, delayed by STAGES clock edges.
// BEHAVIOUR
//   - Single clock domain. Reset is synchronous and active-high.
//   - Reset: rst=1 at a posedge clears every pipeline stage and out to 0.
//   - Reset while data is in flight discards that data; no partial result
//     survives.
//   - The first valid result appears STAGES edges after rst is released.
//   - Power-up: all stages initialise to 0, so out=0 before the first edge.
//     No X on out in zero-delay simulation.
//   - Normal operation: at each posedge, stage[0] <= a & b and
//     stage[i] <= stage[i-1]; out = stage[STAGES-1].
//   - Latency: STAGES edges (default 1); throughput is one result per cycle.
//   - out is a pure register output; no combinational path from a/b to out.
//   - a/b changes between edges never affect out. Only values at the posedge
//     matter, including glitches and multiple toggles within one period.
//   - Width rule: out[i] = a[i] & b[i]. No carry or reduction across lanes.
//   - Illegal STAGES (<1 or >8): elaboration error via generate-time
//     $error. No clamping.
// CONFIGURATION
//   BASIC_AND_TIMING_EN
//     Defined: adds a specify block with clk->out edge path delay
//       (default 10ps), plus $setup/$hold checks (default 5ps) for a and b
//       against posedge clk. These arcs are the targets of SDF annotation.
//       A timing violation toggles a notifier that forces the affected
//       stage to X.
//     Undefined: no specify block; zero-delay RTL; no timing checks.
//       Functionally identical.
// TESTING
//   - Reset: rst=1 for 2 edges, a=1, b=1 -> out=0 throughout.
//     Release rst -> out=1 after STAGES edges.
//   - Truth table (WIDTH=1, STAGES=1): apply a/b = 00, 01, 10, 11 on
//     successive edges -> out = 0, 0, 0, 1, one edge later each.
//   - Between-edge toggles: with clk static, toggle a 0->1->0 and b 0->1.
//     Next posedge samples a=0, b=1 -> out stays 0. Then a=1 before the next
//     edge -> out=1.
//   - Pipeline (WIDTH=8, STAGES=3): stream a=FF, b=0F, then a=A5, b=FF ->
//     out=0F at edge 3 and A5 at edge 4.
//   - Mid-flight reset (STAGES=3): load three results, assert rst for one
//     edge -> out=00 immediately. The discarded values never appear.
//   - With BASIC_AND_TIMING_EN defined, change a 2ps before posedge ->
//     setup violation reported, and the sampled stage goes X.

Source files
------------

// File: rtl/basic_and_ff.sv
// basic_and_ff: registered bitwise AND, STAGES-deep pipeline, sync reset.
// Ports: clk, rst (sync, active-high), a/b [WIDTH], out [WIDTH] = a&b delayed.
// Option: BASIC_AND_TIMING_EN adds specify arcs, setup/hold checks, notifier.
`timescale 1ns/1ps
module basic_and_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out
);

  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("basic_and_ff: STAGES must be 1..8");
  end

  // Declaration-time zero keeps out free of X before the first edge.
  logic [WIDTH-1:0] stage_q [STAGES] = '{default: '0};

`ifdef BASIC_AND_TIMING_EN
  reg   notifier  = 1'b0;
  logic note_seen = 1'b0;

  specify
    specparam t_cq = 0.010;
    specparam t_su = 0.005;
    specparam t_ho = 0.005;
    (posedge clk => (out +: a)) = t_cq;
    $setup(a, posedge clk, t_su, notifier);
    $hold(posedge clk, a, t_ho, notifier);
    $setup(b, posedge clk, t_su, notifier);
    $hold(posedge clk, b, t_ho, notifier);
  endspecify

  // A notifier toggle since the last edge poisons the captured sample.
  always_ff @(posedge clk) begin
    note_seen <= notifier;
    if (rst) begin
      for (int i = 0; i < STAGES; i++)
        stage_q[i] <= '0;
    end else begin
      if (notifier !== note_seen)
        stage_q[0] <= 'x;
      else
        stage_q[0] <= a & b;
      for (int i = 1; i < STAGES; i++)
        stage_q[i] <= stage_q[i-1];
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++)
        stage_q[i] <= '0;
    end else begin
      stage_q[0] <= a & b;
      for (int i = 1; i < STAGES; i++)
        stage_q[i] <= stage_q[i-1];
    end
  end
`endif

  assign out = stage_q[STAGES-1];

endmodule

// File: tb/tb_basic_and_ff.sv
// tb_basic_and_ff: directed checks of basic_and_ff.
// Two instances: WIDTH=1/STAGES=1 and WIDTH=8/STAGES=3.
`timescale 1ns/1ps
module tb_basic_and_ff;

  logic       clk = 1'b0;
  logic       rst;
  logic       a1, b1, o1;
  logic [7:0] a3, b3, o3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  basic_and_ff #(.WIDTH(1), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .out(o1)
  );

  basic_and_ff #(.WIDTH(8), .STAGES(3)) u_s3 (
    .clk(clk), .rst(rst), .a(a3), .b(b3), .out(o3)
  );

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] tt [4];
  logic       tt_exp [4];

  initial begin
    tt[0] = 2'b00; tt_exp[0] = 1'b0;
    tt[1] = 2'b01; tt_exp[1] = 1'b0;
    tt[2] = 2'b10; tt_exp[2] = 1'b0;
    tt[3] = 2'b11; tt_exp[3] = 1'b1;

    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1;
    a3 = 8'hFF; b3 = 8'hFF;
    #1;
    check("pwrup_s1", {7'd0, o1}, 8'h00);
    check("pwrup_s3", o3, 8'h00);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_s1", {7'd0, o1}, 8'h00);
      check("rst_s3", o3, 8'h00);
    end

    rst = 1'b0;
    tick();
    check("rel_s1_e1", {7'd0, o1}, 8'h01);
    check("rel_s3_e1", o3, 8'h00);
    tick();
    check("rel_s3_e2", o3, 8'h00);
    tick();
    check("rel_s3_e3", o3, 8'hFF);

    for (int i = 0; i < 4; i++) begin
      a1 = tt[i][1];
      b1 = tt[i][0];
      tick();
      check("truth", {7'd0, o1}, {7'd0, tt_exp[i]});
    end

    a1 = 1'b0; b1 = 1'b0;
    tick();
    check("glitch_base", {7'd0, o1}, 8'h00);
    a1 = 1'b1; #1;
    a1 = 1'b0; #1;
    b1 = 1'b1;
    tick();
    check("glitch_hold", {7'd0, o1}, 8'h00);
    a1 = 1'b1;
    tick();
    check("glitch_set", {7'd0, o1}, 8'h01);

    a3 = 8'hFF; b3 = 8'h0F;
    tick();
    a3 = 8'hA5; b3 = 8'hFF;
    tick();
    a3 = 8'h00; b3 = 8'h00;
    tick();
    check("pipe_e3", o3, 8'h0F);
    tick();
    check("pipe_e4", o3, 8'hA5);
    tick();
    check("pipe_e5", o3, 8'h00);

    b3 = 8'hFF;
    a3 = 8'h11; tick();
    a3 = 8'h22; tick();
    a3 = 8'h33; tick();
    check("mid_load", o3, 8'h11);
    a3 = 8'h44;
    rst = 1'b1;
    tick();
    check("mid_rst_s3", o3, 8'h00);
    check("mid_rst_s1", {7'd0, o1}, 8'h00);
    rst = 1'b0;
    a3 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_flush", o3, 8'h00);
    end

    a3 = 8'h5A; b3 = 8'hF0;
    tick(); tick(); tick();
    check("lanes", o3, 8'h50);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
